// File: rtl/matmul_pkg.sv
// Shared matrix-multiply definitions: dimensions, loader state encoding and the B offset map.
// RAM_B_TRANSPOSE_EN selects the column-major B layout in b_offset().
package matmul_pkg;

   localparam int MAT_N  = 8;
   localparam int ELEM_W = 8;

   typedef enum logic [1:0] {
      LDR_IDLE = 2'd0,
      LDR_LOAD = 2'd1,
      LDR_DONE = 2'd2
   } ldr_state_t;

   // Reader and writer both call this so the two sides can never disagree on layout.
   function automatic int unsigned b_offset(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned n);
`ifdef RAM_B_TRANSPOSE_EN
      return col * n + row;
`else
      return row * n + col;
`endif
   endfunction

endpackage

// File: rtl/ram_b_addr_gen.sv
// Row/col walker for the B loader: row-major stream position, mapped offset and last-element flag.
// The layout follows RAM_B_TRANSPOSE_EN through matmul_pkg::b_offset.
module ram_b_addr_gen import matmul_pkg::*; #(
   parameter  int N     = MAT_N,
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1,
   localparam int OFF_W = (N > 1) ? $clog2(N * N) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             restart,
   input  logic             adv,
   output logic [OFF_W-1:0] offset,
   output logic             last
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(N - 1);

   logic [CNT_W-1:0] row;
   logic [CNT_W-1:0] col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (restart) begin
         row <= '0;
         col <= '0;
      end else if (adv) begin
         if (col == CNT_MAX) begin
            col <= '0;
            row <= (row == CNT_MAX) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last   = (row == CNT_MAX) && (col == CNT_MAX);
   assign offset = OFF_W'(b_offset(32'(row), 32'(col), 32'(N)));

endmodule

// File: rtl/ram_b_loader.sv
// Matrix-B RAM write-side loader: one registered RAM write per accepted stream element.
// Build with RAM_B_TRANSPOSE_EN to store B column-major.
module ram_b_loader import matmul_pkg::*; #(
   parameter  int N         = MAT_N,
   parameter  int DATA_W    = ELEM_W,
   parameter  int ADDR_W    = 8,
   parameter  int BASE_ADDR = 0,
   localparam int OFF_W     = (N > 1) ? $clog2(N * N) : 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     clr,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     in_ready,
   output logic                     ram_we,
   output logic        [ADDR_W-1:0] ram_addr,
   output logic signed [DATA_W-1:0] ram_din,
   output logic                     busy,
   output logic                     done
);

   // state    | meaning
   // LDR_IDLE | waiting for start, in_ready low
   // LDR_LOAD | accepting elements, one RAM write per accept
   // LDR_DONE | final write on the RAM port this cycle, done high

   ldr_state_t       state_q;
   ldr_state_t       state_d;
   logic             accept;
   logic             start_go;
   logic             last;
   logic [OFF_W-1:0] offset;

   assign in_ready = (state_q == LDR_LOAD) && !clr;
   assign accept   = in_valid && in_ready;
   assign start_go = (state_q == LDR_IDLE) && start && !clr;
   assign busy     = (state_q == LDR_LOAD);
   assign done     = (state_q == LDR_DONE);

   // Counters restart on entry to LOAD so an aborted load leaves no trace.
   ram_b_addr_gen #(.N(N)) u_addr_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (clr || start_go),
      .adv     (accept),
      .offset  (offset),
      .last    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= LDR_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = LDR_IDLE;
      end else begin
         unique case (state_q)
            LDR_IDLE: if (start)          state_d = LDR_LOAD;
            LDR_LOAD: if (accept && last) state_d = LDR_DONE;
            LDR_DONE:                     state_d = LDR_IDLE;
            default:                      state_d = LDR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_we   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
      end else begin
         ram_we <= accept;
         if (accept) begin
            ram_addr <= ADDR_W'(32'(BASE_ADDR) + 32'(offset));
            ram_din  <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_ram_b_loader.sv
// Self-checking bench for ram_b_loader: two instances (base 0 and base 64) against a stream-count model.
// Honours RAM_B_TRANSPOSE_EN for the expected address layout.
module tb_ram_b_loader;

   localparam int N  = 8;
   localparam int NN = N * N;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              clr = 1'b0;
   logic              in_valid = 1'b0;
   logic signed [7:0] in_data = '0;

   logic              in_ready0, ram_we0, busy0, done0;
   logic        [7:0] ram_addr0;
   logic signed [7:0] ram_din0;
   logic              in_ready1, ram_we1, busy1, done1;
   logic        [7:0] ram_addr1;
   logic signed [7:0] ram_din1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: stream position, not RTL state.
   bit                m_loading, m_done, m_we;
   int                m_k;
   logic        [7:0] m_addr0, m_addr1;
   logic signed [7:0] m_din;
   int                obs_writes, obs_dones;

   ram_b_loader #(.N(N), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready0), .ram_we(ram_we0), .ram_addr(ram_addr0),
      .ram_din(ram_din0), .busy(busy0), .done(done0));

   ram_b_loader #(.N(N), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(64)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready1), .ram_we(ram_we1), .ram_addr(ram_addr1),
      .ram_din(ram_din1), .busy(busy1), .done(done1));

   initial forever #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // k-th element of the row-major stream is (row k/N, col k%N).
   function automatic logic [7:0] exp_addr(input int base, input int k);
      int r;
      int c;
      r = k / N;
      c = k % N;
`ifdef RAM_B_TRANSPOSE_EN
      return 8'(base + c * N + r);
`else
      return 8'(base + r * N + c);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0;
      m_done    = 0;
      m_we      = 0;
      m_k       = 0;
      m_addr0   = '0;
      m_addr1   = '0;
      m_din     = '0;
   endtask

   task automatic check_outs();
      chk("ram_we",    ram_we0,   m_we);
      chk("ram_addr",  ram_addr0, m_addr0);
      chk("ram_din",   ram_din0,  m_din);
      chk("done",      done0,     m_done);
      chk("busy",      busy0,     m_loading);
      chk("ram_we_b64",   ram_we1,   m_we);
      chk("ram_addr_b64", ram_addr1, m_addr1);
      chk("ram_din_b64",  ram_din1,  m_din);
      chk("done_b64",     done1,     m_done);
      chk("busy_b64",     busy1,     m_loading);
      if (ram_we0) obs_writes++;
      if (done0)   obs_dones++;
   endtask

   task automatic step(input bit s, input bit c, input bit v, input logic [7:0] d);
      bit was_loading;
      bit was_done;
      bit acc;
      @(negedge clk);
      start = s; clr = c; in_valid = v; in_data = d;
      #1;
      was_loading = m_loading;
      was_done    = m_done;
      chk("in_ready",     in_ready0, was_loading && !c);
      chk("in_ready_b64", in_ready1, was_loading && !c);
      acc    = v && was_loading && !c;
      m_we   = acc;
      m_done = 0;
      if (acc) begin
         m_addr0 = exp_addr(0, m_k);
         m_addr1 = exp_addr(64, m_k);
         m_din   = d;
         m_k++;
         if (m_k == NN) begin
            m_loading = 0;
            m_done    = 1;
         end
      end
      if (c) m_loading = 0;
      else if (s && !was_loading && !was_done) begin
         m_loading = 1;
         m_k       = 0;
      end
      @(posedge clk);
      #1;
      check_outs();
   endtask

   function automatic logic [7:0] pick_data();
      case ($urandom_range(0, 2))
         0:       return 8'h80;
         1:       return 8'h7F;
         default: return 8'($urandom);
      endcase
   endfunction

   initial begin
      int guard;
      int w0;
      int d0;
      model_reset();
      obs_writes = 0;
      obs_dones  = 0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready0, 0);
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;

      // Full ordered stream, valid held high
      step(1, 0, 0, 0);
      for (int k = 0; k < NN; k++) step(0, 0, 1, 8'(k));
      step(0, 0, 0, 0);

      // Random valid with extreme data values
      step(1, 0, 0, 0);
      guard = 0;
      while (m_loading && guard < 1000) begin
         step(0, 0, 1'($urandom_range(0, 1)), pick_data());
         guard++;
      end
      chk("random_load_finished", guard < 1000, 1);
      step(0, 0, 1, 8'h80);

      // Abort after 20 accepts, then a clean full load
      step(1, 0, 0, 0);
      for (int k = 0; k < 20; k++) step(0, 0, 1, pick_data());
      step(0, 1, 1, 8'h55);
      step(0, 0, 1, 8'h66);
      w0 = obs_writes;
      d0 = obs_dones;
      step(1, 0, 1, 8'h77);
      for (int k = 0; k < NN; k++) step(0, 0, 1, 8'(200 + k));
      step(0, 0, 0, 0);
      chk("restart_write_count", obs_writes - w0, NN);
      chk("restart_done_count",  obs_dones - d0, 1);

      // Start pulses during LOAD and DONE, valid while IDLE
      step(1, 0, 0, 0);
      for (int k = 0; k < NN; k++) step((k % 9) == 4, 0, 1, pick_data());
      step(1, 0, 1, 8'h11);
      for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h22);

      // start and clr together: clr wins
      step(1, 1, 1, 8'h33);
      step(0, 0, 1, 8'h44);

      // Async reset mid-load, between edges
      step(1, 0, 0, 0);
      for (int k = 0; k < 10; k++) step(0, 0, 1, pick_data());
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_in_ready", in_ready0, 0);
      check_outs();
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h5A);

      // Clean load after reset to confirm recovery
      step(1, 0, 0, 0);
      for (int k = 0; k < NN; k++) step(0, 0, 1, pick_data());
      step(0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
